id_ex_pipe: RTL

ID/EX pipeline register for the 8-bit, 4-register pipelined core, with integrated load-use hazard detection. Captures decoded control, register addresses and operands from ID and presents them to EX, where they drive the forwarding unit (Rs_EX, Rt_EX) and the ALU muxes. Inserts one bubble on a load-use dependency, and raises Stall_ID to freeze the PC and the IF/ID register. Also handles branch flush and a global pipeline hold.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit, 4-register pipelined core.
// Used by ID, EX, the forwarding unit and the ID/EX pipeline register.
//   DATA_W  : operand / immediate / PC width
//   REG_AW  : register address width
//   ALUOP_W : ALU opcode width
//   alu_op_e: ALU opcode encodings decoded in ID and executed in EX
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 2;
    localparam int ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SLT  = 4'h7,
        ALU_PASS = 4'h8
    } alu_op_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags a hazard when the instruction in EX is a valid load whose
// destination is a source actually read by the valid instruction in ID.
//   valid_id_i, uses_rs_i, uses_rt_i : ID instruction validity / operand use
//   rs_i, rt_i                       : ID source register addresses
//   valid_ex_i, mem_read_ex_i, rd_ex_i : EX instruction state
//   haz_o                            : load-use hazard
module load_use_detect #(
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              valid_id_i,
    input  logic              uses_rs_i,
    input  logic              uses_rt_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic              valid_ex_i,
    input  logic              mem_read_ex_i,
    input  logic [REG_AW-1:0] rd_ex_i,
    output logic              haz_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = uses_rs_i & (rs_i == rd_ex_i);
    assign rt_match = uses_rt_i & (rt_i == rd_ex_i);
    assign haz_o    = valid_ex_i & mem_read_ex_i & (rs_match | rt_match) & valid_id_i;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion.
// Captures decoded control, register addresses and operands from ID and
// presents them to EX. A load-use hazard loads a bubble and raises
// Stall_ID; a taken branch (Flush_EX) loads a bubble without stalling;
// Hold freezes everything.
//   clk, rst            : clock, synchronous active-high reset
//   Hold, Flush_EX      : global freeze, branch flush
//   *_ID                : decoded instruction from ID
//   *_EX                : registered instruction presented to EX
//   Stall_ID            : combinational freeze request for PC and IF/ID
//   BubbleCnt           : saturating count of hazard bubbles
module id_ex_pipe #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int REG_AW  = cpu_pkg::REG_AW,
    parameter int ALUOP_W = cpu_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Hold,
    input  logic               Flush_EX,
    input  logic               Valid_ID,
    input  logic               RegWrite_ID,
    input  logic               MemRead_ID,
    input  logic               MemWrite_ID,
    input  logic               MemToReg_ID,
    input  logic               ALUSrc_ID,
    input  logic               UsesRs_ID,
    input  logic               UsesRt_ID,
    input  logic [ALUOP_W-1:0] ALUOp_ID,
    input  logic [REG_AW-1:0]  Rs_ID,
    input  logic [REG_AW-1:0]  Rt_ID,
    input  logic [REG_AW-1:0]  Rd_ID,
    input  logic [DATA_W-1:0]  ReadData1_ID,
    input  logic [DATA_W-1:0]  ReadData2_ID,
    input  logic [DATA_W-1:0]  Imm_ID,
    input  logic [DATA_W-1:0]  PC_ID,
    output logic               Valid_EX,
    output logic               RegWrite_EX,
    output logic               MemRead_EX,
    output logic               MemWrite_EX,
    output logic               MemToReg_EX,
    output logic               ALUSrc_EX,
    output logic [ALUOP_W-1:0] ALUOp_EX,
    output logic [REG_AW-1:0]  Rs_EX,
    output logic [REG_AW-1:0]  Rt_EX,
    output logic [REG_AW-1:0]  Rd_EX,
    output logic [DATA_W-1:0]  ReadData1_EX,
    output logic [DATA_W-1:0]  ReadData2_EX,
    output logic [DATA_W-1:0]  Imm_EX,
    output logic [DATA_W-1:0]  PC_EX,
    output logic               Stall_ID,
    output logic [CNT_W-1:0]   BubbleCnt
);

    // All stored fields travel as one packed word so a bubble is simply '0.
    localparam int STAGE_W = 6 + ALUOP_W + 3 * REG_AW + 4 * DATA_W;

    logic [STAGE_W-1:0] id_bundle;
    logic [STAGE_W-1:0] stage_q;
    logic [STAGE_W-1:0] stage_d;
    logic [CNT_W-1:0]   bubble_cnt_q;
    logic [CNT_W-1:0]   bubble_cnt_d;
    logic               haz;

    assign id_bundle = {Valid_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID,
                        ALUSrc_ID, ALUOp_ID, Rs_ID, Rt_ID, Rd_ID,
                        ReadData1_ID, ReadData2_ID, Imm_ID, PC_ID};

    assign {Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX,
            ALUSrc_EX, ALUOp_EX, Rs_EX, Rt_EX, Rd_EX,
            ReadData1_EX, ReadData2_EX, Imm_EX, PC_EX} = stage_q;

    assign BubbleCnt = bubble_cnt_q;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .valid_id_i    (Valid_ID),
        .uses_rs_i     (UsesRs_ID),
        .uses_rt_i     (UsesRt_ID),
        .rs_i          (Rs_ID),
        .rt_i          (Rt_ID),
        .valid_ex_i    (Valid_EX),
        .mem_read_ex_i (MemRead_EX),
        .rd_ex_i       (Rd_EX),
        .haz_o         (haz)
    );

    // A flush discards the ID instruction upstream, so the hazard is moot
    // and the fetch redirect must not be stalled.
    assign Stall_ID = Hold | (haz & ~Flush_EX);

    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!Hold) begin
            if (Flush_EX) begin
                stage_d = '0;
            end else if (haz) begin
                stage_d = '0;
                if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                    bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
                end
            end else begin
                stage_d = id_bundle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule
